// File: rtl/sweep_dwell_ctrl_pkg.sv
// Shared widths and FSM state encoding for the profile-sweep dwell controller.
package sweep_pkg;
  localparam int PROFILE_W  = 3;
  localparam int DWELL_W    = 32;
  localparam int SETTLE_W   = 16;
  localparam int GPIO_W     = 14;
  localparam int GPIO_SHIFT = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_e;
endpackage

// File: rtl/sweep_dwell_ctrl_if.sv
// Host-side control/config and sweep outputs of sweep_dwell_ctrl.
// sweep_count_o exists only with SWEEP_DWELL_SWEEP_COUNT_EN defined.
interface sweep_dwell_ctrl_if #(
  parameter int PROFILE_W = sweep_pkg::PROFILE_W,
  parameter int DWELL_W   = sweep_pkg::DWELL_W,
  parameter int SETTLE_W  = sweep_pkg::SETTLE_W,
  parameter int GPIO_W    = sweep_pkg::GPIO_W
);
  import sweep_pkg::*;

  logic                 start;
  logic                 stop;
  logic [PROFILE_W-1:0] last_profile;
  logic [DWELL_W-1:0]   dwell_cycles;
  logic [SETTLE_W-1:0]  settle_cycles;
  logic                 continuous;
  logic [PROFILE_W-1:0] profile_o;
  logic [GPIO_W-1:0]    gpio_o;
  logic                 step_o;
  logic                 sample_valid_o;
  logic                 busy_o;
  logic                 sweep_done_o;
`ifdef SWEEP_DWELL_SWEEP_COUNT_EN
  logic [31:0]          sweep_count_o;
`endif

  modport master (
`ifdef SWEEP_DWELL_SWEEP_COUNT_EN
    input  sweep_count_o,
`endif
    output start, stop, last_profile, dwell_cycles, settle_cycles, continuous,
    input  profile_o, gpio_o, step_o, sample_valid_o, busy_o, sweep_done_o
  );

  modport slave (
`ifdef SWEEP_DWELL_SWEEP_COUNT_EN
    output sweep_count_o,
`endif
    input  start, stop, last_profile, dwell_cycles, settle_cycles, continuous,
    output profile_o, gpio_o, step_o, sample_valid_o, busy_o, sweep_done_o
  );
endinterface

// File: rtl/sweep_dwell_ctrl_timer.sv
// Loadable down-counter; tc_o is registered and high in the last cycle of a
// loaded interval (a load of 0 or 1 flags the very first cycle).
module sweep_dwell_timer #(
  parameter int DWELL_W = sweep_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               tc_o
);
  import sweep_pkg::*;

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (load_i) begin
      cnt_d = load_val_i;
      tc_d  = (load_val_i <= DWELL_W'(1));
    end else if (en_i && cnt_q != '0) begin
      // flag follows the count one step ahead so it lines up with the final cycle
      cnt_d = cnt_q - DWELL_W'(1);
      tc_d  = (cnt_q == DWELL_W'(2));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;
endmodule

// File: rtl/sweep_dwell_ctrl.sv
// Steps a fast-lock profile index 0..last with settle then dwell per profile.
// Optional sweep counter output under SWEEP_DWELL_SWEEP_COUNT_EN.
module sweep_dwell_ctrl #(
  parameter int PROFILE_W  = sweep_pkg::PROFILE_W,
  parameter int DWELL_W    = sweep_pkg::DWELL_W,
  parameter int SETTLE_W   = sweep_pkg::SETTLE_W,
  parameter int GPIO_W     = sweep_pkg::GPIO_W,
  parameter int GPIO_SHIFT = sweep_pkg::GPIO_SHIFT
) (
  input logic               clk,
  input logic               reset_n,
  sweep_dwell_ctrl_if.slave bus
);
  import sweep_pkg::*;

  state_e               state_q, state_d;
  logic [PROFILE_W-1:0] profile_q, profile_d, last_q;
  logic [GPIO_W-1:0]    gpio_q, gpio_d;
  logic                 step_q, step_d, valid_q, valid_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [DWELL_W-1:0]   dwell_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic                 cont_q;
  logic                 accept, tmr_ld, tmr_en, tmr_tc;
  logic [DWELL_W-1:0]   tmr_val;

  function automatic logic [DWELL_W-1:0] dwell_len(input logic [DWELL_W-1:0] c);
    return (c == '0) ? DWELL_W'(1) : c;
  endfunction

  assign accept = (state_q == IDLE) && bus.start && !bus.stop;

  sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_ld),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    profile_d = profile_q;
    step_d    = 1'b0;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_ld    = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      IDLE: if (accept) begin
        profile_d = '0;
        step_d    = 1'b1;
        busy_d    = 1'b1;
        tmr_ld    = 1'b1;
        if (bus.settle_cycles != '0) begin
          state_d = SETTLE;
          tmr_val = DWELL_W'(bus.settle_cycles);
        end else begin
          state_d = DWELL;
          tmr_val = dwell_len(bus.dwell_cycles);
          valid_d = 1'b1;
        end
      end
      SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d = DWELL;
          tmr_ld  = 1'b1;
          tmr_val = dwell_len(dwell_q);
          valid_d = 1'b1;
        end
      end
      DWELL: begin
        tmr_en  = 1'b1;
        valid_d = 1'b1;
        if (tmr_tc) begin
          if (profile_q != last_q || cont_q) begin
            // advance, or wrap to 0 and flag the completed sweep in the same cycle
            profile_d = (profile_q != last_q) ? profile_q + 1'b1 : '0;
            done_d    = (profile_q == last_q);
            step_d    = 1'b1;
            tmr_ld    = 1'b1;
            if (settle_q != '0) begin
              state_d = SETTLE;
              tmr_val = DWELL_W'(settle_q);
              valid_d = 1'b0;
            end else begin
              tmr_val = dwell_len(dwell_q);
            end
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.stop) begin
      state_d   = IDLE;
      profile_d = '0;
      step_d    = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      tmr_ld    = 1'b0;
      tmr_en    = 1'b0;
    end
    gpio_d = '0;
    gpio_d[GPIO_SHIFT +: PROFILE_W] = profile_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      profile_q <= '0;
      gpio_q    <= '0;
      step_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      profile_q <= profile_d;
      gpio_q    <= gpio_d;
      step_q    <= step_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= '0;
      dwell_q  <= '0;
      settle_q <= '0;
      cont_q   <= 1'b0;
    end else if (accept) begin
      last_q   <= bus.last_profile;
      dwell_q  <= bus.dwell_cycles;
      settle_q <= bus.settle_cycles;
      cont_q   <= bus.continuous;
    end
  end

`ifdef SWEEP_DWELL_SWEEP_COUNT_EN
  logic [31:0] scnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    scnt_q <= '0;
    else if (accept) scnt_q <= '0;
    else if (done_d) scnt_q <= scnt_q + 32'd1;
  end

  assign bus.sweep_count_o = scnt_q;
`endif

  assign bus.profile_o      = profile_q;
  assign bus.gpio_o         = gpio_q;
  assign bus.step_o         = step_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.busy_o         = busy_q;
  assign bus.sweep_done_o   = done_q;
endmodule
